os_burst_generator: RTL

- Parametrised successor to the single-shot LTSSM ordered-set generator.
- Accepts one 16-symbol ordered set per request and streams it as a burst of back-to-back copies across up to MAX_NUM_LANES lanes, with configurable symbols per beat.
- Adds per-lane enable, per-lane lane-number substitution, per-symbol K flags, repeat count / continuous mode, and graceful stop.
- Sits between the LTSSM and the per-lane TX framing/scrambler path. Drives AXIS directly from an internal output register, with no skid buffer.

---
 rtl/os_burst_generator_if.sv | 30 +++
 rtl/os_burst_generator.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/os_burst_generator_if.sv
// os_burst_generator_if: request and AXI-Stream bundle for the ordered-set burst generator
interface os_burst_generator_if #(
  parameter int MAX_NUM_LANES = 4,
  parameter int SYMS_PER_BEAT = 4,
  parameter int OS_SYMS       = 16,
  parameter int REPEAT_W      = 8
);
  localparam int NB = SYMS_PER_BEAT*MAX_NUM_LANES;
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [8*OS_SYMS-1:0]     req_os_i;
  logic [OS_SYMS-1:0]       req_kmask_i;
  logic [REPEAT_W-1:0]      req_repeat_i;
  logic [MAX_NUM_LANES-1:0] req_lane_en_i;
  logic                     req_set_lane_i;
  logic [8*NB-1:0]          m_axis_tdata;
  logic [NB-1:0]            m_axis_tkeep;
  logic [NB-1:0]            m_axis_tuser;
  logic                     m_axis_tvalid;
  logic                     m_axis_tlast;
  logic                     m_axis_tready;
  modport master (
    input  req_valid_i, req_os_i, req_kmask_i, req_repeat_i, req_lane_en_i, req_set_lane_i, m_axis_tready,
    output req_ready_o, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast
  );
  modport slave (
    output req_valid_i, req_os_i, req_kmask_i, req_repeat_i, req_lane_en_i, req_set_lane_i, m_axis_tready,
    input  req_ready_o, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/os_burst_generator.sv
// os_burst_generator: streams an ordered set as a burst of back-to-back copies across lanes
module os_burst_generator #(
  parameter int MAX_NUM_LANES = 4,
  parameter int SYMS_PER_BEAT = 4,
  parameter int OS_SYMS       = 16,
  parameter int REPEAT_W      = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stop_i,
  output logic busy_o,
  output logic os_sent_o,
  output logic burst_done_o,
  os_burst_generator_if.master bus
);
  localparam int BEATS = OS_SYMS/SYMS_PER_BEAT;
  localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int NB    = SYMS_PER_BEAT*MAX_NUM_LANES;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS-1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t                   r_state, w_state_nxt;
  logic [8*OS_SYMS-1:0]     r_os, w_os;
  logic [OS_SYMS-1:0]       r_kmask, w_kmask;
  logic [REPEAT_W-1:0]      r_repeat, w_repeat, r_os_cnt, w_os_cnt;
  logic [MAX_NUM_LANES-1:0] r_lane_en, w_lane_en;
  logic                     r_set_lane, w_set_lane, r_stop, w_stop;
  logic [CNT_W-1:0]         r_beat_cnt, w_beat;
  logic [8*NB-1:0]          r_tdata, w_tdata;
  logic [NB-1:0]            r_tkeep, w_tkeep, r_tuser, w_tuser;
  logic                     r_tvalid, r_tlast, r_tfinal, r_os_sent, r_burst_done;
  logic                     w_acc, w_active, w_adv, w_emit, w_last, w_final, w_done, w_hs_last;
  // The accepting cycle works from the live request so beat 0 can load without a bubble
  assign bus.req_ready_o = (r_state == IDLE);
  assign w_acc      = bus.req_valid_i && bus.req_ready_o;
  assign w_active   = w_acc || (r_state == SEND);
  assign w_adv      = !r_tvalid || bus.m_axis_tready;
  assign w_os       = w_acc ? bus.req_os_i       : r_os;
  assign w_kmask    = w_acc ? bus.req_kmask_i    : r_kmask;
  assign w_repeat   = w_acc ? bus.req_repeat_i   : r_repeat;
  assign w_lane_en  = w_acc ? bus.req_lane_en_i  : r_lane_en;
  assign w_set_lane = w_acc ? bus.req_set_lane_i : r_set_lane;
  assign w_beat     = w_acc ? '0 : r_beat_cnt;
  assign w_os_cnt   = w_acc ? '0 : r_os_cnt;
  assign w_stop     = !w_acc && (r_stop || stop_i);
  assign w_last     = (w_beat == LAST_BEAT);
  assign w_final    = (w_repeat != '0 && w_os_cnt == w_repeat - REPEAT_W'(1)) || w_stop;
  assign w_emit     = w_active && w_adv && |w_lane_en;
  assign w_done     = w_active && (!(|w_lane_en) || (w_emit && w_last && w_final));
  assign w_hs_last  = r_tvalid && bus.m_axis_tready && r_tlast;
  assign bus.m_axis_tdata  = r_tdata;
  assign bus.m_axis_tkeep  = r_tkeep;
  assign bus.m_axis_tuser  = r_tuser;
  assign bus.m_axis_tvalid = r_tvalid;
  assign bus.m_axis_tlast  = r_tlast;
  assign busy_o       = (r_state != IDLE) || r_tvalid;
  assign os_sent_o    = r_os_sent;
  assign burst_done_o = r_burst_done;
  // Next state: stay in SEND until the last beat of the final copy is loaded
  always_comb begin
    w_state_nxt = IDLE;
    w_state_nxt = (w_active && !w_done) ? SEND : IDLE;
  end
  // Build the beat for every lane, optionally substituting the lane number into symbol 2
  always_comb begin
    w_tdata = '0;
    w_tkeep = '0;
    w_tuser = '0;
    for (int l = 0; l < MAX_NUM_LANES; l++) begin
      for (int j = 0; j < SYMS_PER_BEAT; j++) begin
        int  s;
        int  p;
        logic sub;
        s   = int'(w_beat)*SYMS_PER_BEAT + j;
        p   = l*SYMS_PER_BEAT + j;
        sub = w_set_lane && (s == 2);
        if (w_lane_en[l]) begin
          w_tkeep[p]       = 1'b1;
          w_tdata[p*8 +: 8] = sub ? 8'(l) : w_os[s*8 +: 8];
          w_tuser[p]       = !sub && w_kmask[s];
        end
      end
    end
  end
  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  // Request latch, stop latch and beat/copy counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_os       <= '0;
      r_kmask    <= '0;
      r_repeat   <= '0;
      r_lane_en  <= '0;
      r_set_lane <= 1'b0;
      r_stop     <= 1'b0;
      r_beat_cnt <= '0;
      r_os_cnt   <= '0;
    end else begin
      if (w_acc) begin
        r_os       <= bus.req_os_i;
        r_kmask    <= bus.req_kmask_i;
        r_repeat   <= bus.req_repeat_i;
        r_lane_en  <= bus.req_lane_en_i;
        r_set_lane <= bus.req_set_lane_i;
      end
      r_stop     <= w_acc ? 1'b0 : (r_stop || (r_state == SEND && stop_i));
      r_beat_cnt <= w_emit ? (w_last ? '0 : w_beat + CNT_W'(1)) : w_beat;
      r_os_cnt   <= (w_emit && w_last) ? w_os_cnt + REPEAT_W'(1) : w_os_cnt;
    end
  end
  // Output register: loads on advance, holds while stalled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tuser  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tfinal <= 1'b0;
    end else if (w_adv) begin
      r_tdata  <= w_emit ? w_tdata : '0;
      r_tkeep  <= w_emit ? w_tkeep : '0;
      r_tuser  <= w_emit ? w_tuser : '0;
      r_tvalid <= w_emit;
      r_tlast  <= w_emit && w_last;
      r_tfinal <= w_emit && w_last && w_final;
    end
  end
  // Status pulses after the closing handshake of each copy and of the burst
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_os_sent    <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      r_os_sent    <= w_hs_last;
      r_burst_done <= (w_hs_last && r_tfinal) || (w_active && !(|w_lane_en));
    end
  end
endmodule
